mips_mem_responder: RTL and testbench

Responder end of the single-cycle core's data-memory interface: it receives memwrite, address (core aluout) and writedata, and returns readdata in the same cycle. The block contains a word-addressed data RAM and a memory-mapped timer/compare peripheral with sticky status and an interrupt line. It sits beside the core in the top level, in place of a plain data memory.

---
 rtl/mips_mem_pkg.sv | 29 ++
 rtl/mips_mem_responder_if.sv | 14 +
 rtl/mips_timer.sv | 83 ++++++++
 rtl/mips_mem_responder.sv | 106 ++++++++++
 tb/tb_mips_mem_responder.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory responder: timer register map,
// CTRL/STATUS bit positions and the address-decode select type.
package mips_mem_pkg;

    localparam logic [31:0] TIMER_BASE   = 32'hFFFF_FF00;
    localparam logic [7:0]  CTRL_OFS     = 8'h00;
    localparam logic [7:0]  PRESCALE_OFS = 8'h04;
    localparam logic [7:0]  COUNT_OFS    = 8'h08;
    localparam logic [7:0]  COMPARE_OFS  = 8'h0C;
    localparam logic [7:0]  STATUS_OFS   = 8'h10;

    localparam int EN_BIT    = 0;
    localparam int AR_BIT    = 1;
    localparam int IE_BIT    = 2;

    localparam int MATCH_BIT = 0;
    localparam int ERR_BIT   = 1;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_CTRL,
        SEL_PRESCALE,
        SEL_COUNT,
        SEL_COMPARE,
        SEL_STATUS
    } sel_e;

endpackage

// File: rtl/mips_mem_responder_if.sv
// Core data-memory bus.
//   memwrite, addr, writedata : core -> responder
//   readdata, irq, err        : responder -> core
interface mips_mem_responder_if;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic        err;

    modport master (output memwrite, addr, writedata, input readdata, irq, err);
    modport slave  (input memwrite, addr, writedata, output readdata, irq, err);
endinterface

// File: rtl/mips_timer.sv
// Timer/compare peripheral: CTRL, PRESCALE, COUNT, COMPARE, prescale counter
// and the sticky match flag.
//   clk, reset          : clock, async active-high reset
//   wr_*                : decoded register write enables from the top
//   wdata               : store data
//   ctrl/prescale/count/compare/match : register state for readback and irq
module mips_timer
    import mips_mem_pkg::*;
#(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_ctrl,
    input  logic                  wr_prescale,
    input  logic                  wr_count,
    input  logic                  wr_compare,
    input  logic                  wr_status,
    input  logic [31:0]           wdata,
    output logic [2:0]            ctrl,
    output logic [PRESCALE_W-1:0] prescale,
    output logic [31:0]           count,
    output logic [31:0]           compare,
    output logic                  match
);

    logic [PRESCALE_W-1:0] pcnt;
    logic                  tick;
    logic                  hit;
    logic [31:0]           count_next;

    // Tick is derived from registered state only, so a CTRL write in the
    // same cycle cannot suppress it.
    assign tick = ctrl[EN_BIT] && (pcnt == prescale);
    assign hit  = (count == compare);

    always_comb begin
        count_next = count + 32'd1;
        if (hit && ctrl[AR_BIT]) begin
            count_next = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl     <= '0;
            prescale <= '0;
            pcnt     <= '0;
            count    <= '0;
            compare  <= '0;
            match    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl <= wdata[2:0];
            end
            if (wr_compare) begin
                compare <= wdata;
            end

            if (wr_prescale) begin
                prescale <= wdata[PRESCALE_W-1:0];
                pcnt     <= '0;
            end else if (ctrl[EN_BIT]) begin
                pcnt <= tick ? '0 : PRESCALE_W'(pcnt + 1'b1);
            end

            // Software load wins over the tick increment.
            if (wr_count) begin
                count <= wdata;
            end else if (tick) begin
                count <= count_next;
            end

            // A new match wins over a simultaneous W1C.
            if (tick && hit) begin
                match <= 1'b1;
            end else if (wr_status && wdata[MATCH_BIT]) begin
                match <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mips_mem_responder.sv
// Data-memory responder beside the single-cycle core: word-addressed RAM plus
// a memory-mapped timer. Reads are combinational; writes land on the clock.
//   clk, reset : clock, async active-high reset
//   bus        : core data bus (memwrite/addr/writedata in, readdata/irq/err out)
module mips_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int RAM_WORDS  = 64,
    parameter int PRESCALE_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    mips_mem_responder_if.slave  bus
);

    localparam int RAM_AW = $clog2(RAM_WORDS);

    logic [31:0]           ram [RAM_WORDS];
    sel_e                  sel;
    logic [RAM_AW-1:0]     word_idx;
    logic                  err;
    logic [2:0]            ctrl;
    logic [PRESCALE_W-1:0] prescale;
    logic [31:0]           count;
    logic [31:0]           compare;
    logic                  match;
    logic [31:0]           status_rd;
    logic                  unused_bits;

    assign unused_bits = &{1'b0, bus.addr[1:0]};
    assign word_idx    = bus.addr[RAM_AW+1:2];

    always_comb begin
        sel = SEL_NONE;
        if (bus.addr[31:RAM_AW+2] == '0) begin
            sel = SEL_RAM;
        end else if (bus.addr[31:8] == TIMER_BASE[31:8]) begin
            case (bus.addr[7:2])
                CTRL_OFS[7:2]:     sel = SEL_CTRL;
                PRESCALE_OFS[7:2]: sel = SEL_PRESCALE;
                COUNT_OFS[7:2]:    sel = SEL_COUNT;
                COMPARE_OFS[7:2]:  sel = SEL_COMPARE;
                STATUS_OFS[7:2]:   sel = SEL_STATUS;
                default:           sel = SEL_NONE;
            endcase
        end
    end

    // RAM is deliberately not reset.
    always_ff @(posedge clk) begin
        if (bus.memwrite && sel == SEL_RAM) begin
            ram[word_idx] <= bus.writedata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (bus.memwrite) begin
            if (sel == SEL_NONE) begin
                err <= 1'b1;
            end else if (sel == SEL_STATUS && bus.writedata[ERR_BIT]) begin
                err <= 1'b0;
            end
        end
    end

    mips_timer #(.PRESCALE_W(PRESCALE_W)) u_timer (
        .clk         (clk),
        .reset       (reset),
        .wr_ctrl     (bus.memwrite && sel == SEL_CTRL),
        .wr_prescale (bus.memwrite && sel == SEL_PRESCALE),
        .wr_count    (bus.memwrite && sel == SEL_COUNT),
        .wr_compare  (bus.memwrite && sel == SEL_COMPARE),
        .wr_status   (bus.memwrite && sel == SEL_STATUS),
        .wdata       (bus.writedata),
        .ctrl        (ctrl),
        .prescale    (prescale),
        .count       (count),
        .compare     (compare),
        .match       (match)
    );

    always_comb begin
        status_rd            = '0;
        status_rd[MATCH_BIT] = match;
        status_rd[ERR_BIT]   = err;
    end

    always_comb begin
        bus.readdata = '0;
        case (sel)
            SEL_RAM:      bus.readdata = ram[word_idx];
            SEL_CTRL:     bus.readdata = 32'(ctrl);
            SEL_PRESCALE: bus.readdata = 32'(prescale);
            SEL_COUNT:    bus.readdata = count;
            SEL_COMPARE:  bus.readdata = compare;
            SEL_STATUS:   bus.readdata = status_rd;
            default:      bus.readdata = '0;
        endcase
    end

    assign bus.irq = match & ctrl[IE_BIT];
    assign bus.err = err;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench for mips_mem_responder (RAM_WORDS=16, PRESCALE_W=16).
module tb_mips_mem_responder;

    localparam logic [31:0] A_CTRL     = 32'hFFFF_FF00;
    localparam logic [31:0] A_PRESCALE = 32'hFFFF_FF04;
    localparam logic [31:0] A_COUNT    = 32'hFFFF_FF08;
    localparam logic [31:0] A_COMPARE  = 32'hFFFF_FF0C;
    localparam logic [31:0] A_STATUS   = 32'hFFFF_FF10;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mips_mem_responder_if bif ();

    mips_mem_responder #(.RAM_WORDS(16), .PRESCALE_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic peek(input logic [31:0] a, input logic [31:0] exp, input string tag);
        bif.addr = a;
        #1;
        chk(tag, bif.readdata, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bif.memwrite  = 1'b1;
        bif.addr      = a;
        bif.writedata = d;
        @(posedge clk);
        #1;
        bif.memwrite  = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bif.memwrite  = 1'b0;
        bif.addr      = '0;
        bif.writedata = '0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;

        // Reset state
        peek(A_CTRL,   32'h0, "rst_ctrl");
        peek(A_COUNT,  32'h0, "rst_count");
        peek(A_STATUS, 32'h0, "rst_status");
        chk("rst_irq", {31'b0, bif.irq}, 32'h0);
        chk("rst_err", {31'b0, bif.err}, 32'h0);

        // RAM write/read and out-of-range reads
        wr(32'h0000_0000, 32'h1111_1111);
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        wr(32'h0000_003C, 32'h1234_5678);
        peek(32'h0000_0010, 32'hDEAD_BEEF, "ram_10");
        peek(32'h0000_003C, 32'h1234_5678, "ram_3c");
        peek(32'h0000_0000, 32'h1111_1111, "ram_00");
        peek(32'h0000_0040, 32'h0, "rd_unmapped_40");
        step(1);
        peek(32'h8000_0000, 32'h0, "rd_unmapped_8000");
        chk("rd_unmapped_no_err", {31'b0, bif.err}, 32'h0);
        wr(A_PRESCALE, 32'hFFFF_1234);
        peek(A_PRESCALE, 32'h0000_1234, "prescale_width");

        // Prescaled counting, match without autoreload
        do_reset();
        wr(A_PRESCALE, 32'd2);
        wr(A_COMPARE, 32'd3);
        wr(A_CTRL, 32'h5);
        step(2);
        peek(A_COUNT, 32'd0, "pre_n2");
        step(1);
        peek(A_COUNT, 32'd1, "pre_n3");
        step(6);
        peek(A_COUNT, 32'd3, "pre_n9");
        peek(A_STATUS, 32'h0, "pre_n9_status");
        chk("pre_n9_irq", {31'b0, bif.irq}, 32'h0);
        step(3);
        peek(A_COUNT, 32'd4, "pre_n12");
        peek(A_STATUS, 32'h1, "pre_n12_status");
        chk("pre_n12_irq", {31'b0, bif.irq}, 32'h1);

        // Autoreload and W1C of match
        do_reset();
        wr(A_PRESCALE, 32'd2);
        wr(A_COMPARE, 32'd3);
        wr(A_CTRL, 32'h7);
        step(9);
        peek(A_COUNT, 32'd3, "ar_n9");
        step(3);
        peek(A_COUNT, 32'd0, "ar_n12");
        peek(A_STATUS, 32'h1, "ar_n12_status");
        wr(A_STATUS, 32'h1);
        peek(A_STATUS, 32'h0, "w1c_offtick");
        chk("w1c_offtick_irq", {31'b0, bif.irq}, 32'h0);
        step(10);
        peek(A_COUNT, 32'd3, "ar_n23");
        wr(A_STATUS, 32'h1);
        peek(A_STATUS, 32'h1, "w1c_on_match");
        peek(A_COUNT, 32'd0, "ar_n24");
        chk("w1c_on_match_irq", {31'b0, bif.irq}, 32'h1);
        step(3);
        peek(A_COUNT, 32'd1, "ar_n27");

        // Wrap, software load vs tick, disable in tick cycle
        do_reset();
        wr(A_COUNT, 32'hFFFF_FFFF);
        wr(A_COMPARE, 32'd5);
        wr(A_PRESCALE, 32'd0);
        wr(A_CTRL, 32'h1);
        step(1);
        peek(A_COUNT, 32'd0, "wrap_count");
        peek(A_STATUS, 32'h0, "wrap_no_match");
        wr(A_COUNT, 32'h100);
        peek(A_COUNT, 32'h100, "load_beats_tick");
        step(1);
        peek(A_COUNT, 32'h101, "tick_after_load");
        wr(A_CTRL, 32'h0);
        peek(A_COUNT, 32'h102, "disable_tick_applies");
        step(2);
        peek(A_COUNT, 32'h102, "disabled_hold");

        // Unmapped write
        wr(32'h8000_0000, 32'h55);
        peek(A_STATUS, 32'h2, "unmapped_wr_status");
        chk("unmapped_wr_err", {31'b0, bif.err}, 32'h1);
        peek(A_COUNT, 32'h102, "unmapped_wr_count");
        peek(32'h0000_0000, 32'h1111_1111, "unmapped_wr_ram0");
        step(1);
        peek(32'h0000_0010, 32'hDEAD_BEEF, "unmapped_wr_ram10");
        wr(A_STATUS, 32'h2);
        peek(A_STATUS, 32'h0, "err_w1c_status");
        chk("err_w1c_err", {31'b0, bif.err}, 32'h0);

        // Asynchronous reset mid-operation
        do_reset();
        wr(A_CTRL, 32'h5);
        wr(A_CTRL, 32'h4);
        peek(A_COUNT, 32'd1, "pre_async_count1");
        wr(A_COUNT, 32'd7);
        wr(32'hFFFF_FF20, 32'h0);
        peek(A_COUNT, 32'd7, "pre_async_count");
        chk("pre_async_irq", {31'b0, bif.irq}, 32'h1);
        chk("pre_async_err", {31'b0, bif.err}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_count", bif.readdata, 32'h0);
        chk("async_irq", {31'b0, bif.irq}, 32'h0);
        chk("async_err", {31'b0, bif.err}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        peek(A_STATUS, 32'h0, "post_async_status");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
